// File: rtl/s_aes_pkg.sv
// rtl/s_aes_pkg.sv - shared S-AES tables, FSM state type and nibble/GF(2^4) helpers
package s_aes_pkg;

    // Nibble i of each table sits at bits [4i+3:4i].
    localparam logic [63:0] SBOX     = 64'h7FEC_3026_581D_BA49;
    localparam logic [63:0] INV_SBOX = 64'hED4C_3206_F871_B95A;
    localparam logic [7:0]  RCON1    = 8'h80;
    localparam logic [7:0]  RCON2    = 8'h30;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY1 = 3'd1,
        KEY2 = 3'd2,
        RND2 = 3'd3,
        RND1 = 3'd4,
        FIN  = 3'd5,
        DONE = 3'd6
    } state_e;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [3:0] sbox_nib(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox_nib(input logic [3:0] n);
        return INV_SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] sub_nib(input logic [15:0] s);
        return {sbox_nib(s[15:12]), sbox_nib(s[11:8]), sbox_nib(s[7:4]), sbox_nib(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
        return {inv_sbox_nib(s[15:12]), inv_sbox_nib(s[11:8]),
                inv_sbox_nib(s[7:4]), inv_sbox_nib(s[3:0])};
    endfunction

    // Self-inverse: the same swap serves as InvShiftRows.
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] inv_mix_columns(input logic [15:0] s);
        return {gf16_mul(4'h9, s[15:12]) ^ gf16_mul(4'h2, s[11:8]),
                gf16_mul(4'h2, s[15:12]) ^ gf16_mul(4'h9, s[11:8]),
                gf16_mul(4'h9, s[7:4])   ^ gf16_mul(4'h2, s[3:0]),
                gf16_mul(4'h2, s[7:4])   ^ gf16_mul(4'h9, s[3:0])};
    endfunction

endpackage

// File: rtl/s_aes_key_step.sv
// rtl/s_aes_key_step.sv - one S-AES key-expansion step producing the next two key words
module s_aes_key_step
    import s_aes_pkg::*;
(
    input  logic [7:0] w_a,
    input  logic [7:0] w_b,
    input  logic [7:0] rcon,
    output logic [7:0] w_next_a,
    output logic [7:0] w_next_b
);

    // RotNib then SubNib: low nibble of w_b goes through the S-box into the high position.
    always_comb begin
        w_next_a = w_a ^ rcon ^ {sbox_nib(w_b[3:0]), sbox_nib(w_b[7:4])};
        w_next_b = w_next_a ^ w_b;
    end

endmodule

// File: rtl/s_aes_decrypt_core.sv
// rtl/s_aes_decrypt_core.sv - iterative S-AES decryptor, one inverse round per cycle
module s_aes_decrypt_core
    import s_aes_pkg::*;
#(
    parameter bit KEY_CACHE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ciphertext,
    input  logic [15:0] initialkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] plaintext,
    output logic        busy
);

    state_e      state;
    logic [15:0] st;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
    logic        cache_valid;
    logic [7:0]  ks_a;
    logic [7:0]  ks_b;
    logic [7:0]  ks_rcon;
    logic [7:0]  ks_next_a;
    logic [7:0]  ks_next_b;
    logic [15:0] rnd2_st;
    logic [15:0] rnd1_st;
    logic        cache_hit;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // A single key-step instance is time-shared between KEY1 (from K0) and KEY2 (from K1).
    assign ks_a    = (state == KEY1) ? k0[15:8] : k1[15:8];
    assign ks_b    = (state == KEY1) ? k0[7:0]  : k1[7:0];
    assign ks_rcon = (state == KEY1) ? RCON1    : RCON2;

    s_aes_key_step u_key_step (
        .w_a      (ks_a),
        .w_b      (ks_b),
        .rcon     (ks_rcon),
        .w_next_a (ks_next_a),
        .w_next_b (ks_next_b)
    );

    assign rnd2_st   = inv_sub_nib(shift_rows(st ^ k2));
    assign rnd1_st   = inv_sub_nib(shift_rows(inv_mix_columns(st ^ k1)));
    assign cache_hit = KEY_CACHE && cache_valid && (initialkey == k0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            st          <= 16'h0;
            k0          <= 16'h0;
            k1          <= 16'h0;
            k2          <= 16'h0;
            cache_valid <= 1'b0;
            out_valid   <= 1'b0;
            plaintext   <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= ciphertext;
                        k0    <= initialkey;
                        state <= cache_hit ? RND2 : KEY1;
                    end
                end
                KEY1: begin
                    k1    <= {ks_next_a, ks_next_b};
                    state <= KEY2;
                end
                KEY2: begin
                    k2          <= {ks_next_a, ks_next_b};
                    cache_valid <= 1'b1;
                    state       <= RND2;
                end
                RND2: begin
                    st    <= rnd2_st;
                    state <= RND1;
                end
                RND1: begin
                    st    <= rnd1_st;
                    state <= FIN;
                end
                FIN: begin
                    plaintext <= st ^ k0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s_aes_decrypt_core.sv
// tb/tb_s_aes_decrypt_core.sv - directed and round-trip bench for s_aes_decrypt_core
module tb_s_aes_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [15:0] ciphertext [2];
    logic [15:0] initialkey [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [15:0] plaintext  [2];
    logic        busy       [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s_aes_decrypt_core #(.KEY_CACHE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .ciphertext(ciphertext[0]), .initialkey(initialkey[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .plaintext(plaintext[0]), .busy(busy[0])
    );

    s_aes_decrypt_core #(.KEY_CACHE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .ciphertext(ciphertext[1]), .initialkey(initialkey[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .plaintext(plaintext[1]), .busy(busy[1])
    );

    localparam logic [63:0] TB_SBOX = 64'h7FEC_3026_581D_BA49;

    function automatic logic [3:0] s4(input logic [3:0] n);
        logic [63:0] t;
        t = TB_SBOX;
        return t[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] x);
        return {s4(x[15:12]), s4(x[11:8]), s4(x[7:4]), s4(x[3:0])};
    endfunction

    function automatic logic [15:0] shr(input logic [15:0] x);
        return {x[15:12], x[3:0], x[7:4], x[11:8]};
    endfunction

    // Forward S-AES encryption, used to build round-trip ciphertexts.
    function automatic logic [15:0] enc(input logic [15:0] p, input logic [15:0] k);
        logic [7:0]  w2, w3, w4, w5;
        logic [15:0] s;
        w2 = k[15:8] ^ 8'h80 ^ {s4(k[3:0]), s4(k[7:4])};
        w3 = w2 ^ k[7:0];
        w4 = w2 ^ 8'h30 ^ {s4(w3[3:0]), s4(w3[7:4])};
        w5 = w4 ^ w3;
        s  = shr(sub16(p ^ k));
        s  = {s[15:12] ^ gm(4'h4, s[11:8]), gm(4'h4, s[15:12]) ^ s[11:8],
              s[7:4] ^ gm(4'h4, s[3:0]),    gm(4'h4, s[7:4]) ^ s[3:0]};
        s  = shr(sub16(s ^ {w2, w3}));
        return s ^ {w4, w5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int d, output int n);
        n = 0;
        while (!out_valid[d] && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input int d, input logic [15:0] c, input logic [15:0] k,
                          input logic [15:0] p, input int lat, input bit early, input string name);
        int n;
        check({name, " idle"}, {in_ready[d], busy[d]}, 2'b10);
        in_valid[d]   = 1'b1;
        ciphertext[d] = c;
        initialkey[d] = k;
        out_ready[d]  = early;
        tick();
        in_valid[d]   = 1'b0;
        ciphertext[d] = ~c;
        initialkey[d] = ~k;
        check({name, " accepted"}, {in_ready[d], busy[d], out_valid[d]}, 3'b010);
        wait_out(d, n);
        check({name, " latency"}, n, lat);
        check({name, " plaintext"}, plaintext[d], p);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check({name, " handshake"}, {out_valid[d], in_ready[d], busy[d], plaintext[d]},
              {3'b010, p});
    endtask

    typedef struct {
        int          d;
        logic [15:0] ct;
        logic [15:0] key;
        logic [15:0] pt;
        int          lat;
        bit          early;
    } vec_t;

    vec_t        tbl[7];
    int          n;
    bit          leaked;
    logic [15:0] last_key, k, p;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 16'h0738, 16'hA73B, 16'h6F6B, 5, 1'b0};
        tbl[1] = '{0, 16'h24EC, 16'h4AF5, 16'hD728, 5, 1'b1};
        tbl[2] = '{0, 16'h24EC, 16'h4AF5, 16'hD728, 5, 1'b0};
        tbl[3] = '{1, 16'h0738, 16'hA73B, 16'h6F6B, 5, 1'b0};
        tbl[4] = '{1, 16'h0738, 16'hA73B, 16'h6F6B, 3, 1'b1};
        tbl[5] = '{1, 16'h24EC, 16'h4AF5, 16'hD728, 5, 1'b0};
        tbl[6] = '{1, 16'h24EC, 16'h4AF5, 16'hD728, 3, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            ciphertext[d] = 16'h0; initialkey[d] = 16'h0;
        end
        #12;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset dut%0d", d),
                  {in_ready[d], out_valid[d], busy[d], plaintext[d]}, {3'b100, 16'h0});
        rst_n = 1'b1;
        tick(); tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("post-reset dut%0d", d),
                  {in_ready[d], out_valid[d], busy[d], plaintext[d]}, {3'b100, 16'h0});

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].d, tbl[i].ct, tbl[i].key, tbl[i].pt, tbl[i].lat, tbl[i].early,
                   $sformatf("vec%0d", i));

        // Stall with in_valid held high: second block enters the cycle after the handshake.
        in_valid[0] = 1'b1; ciphertext[0] = 16'h0738; initialkey[0] = 16'hA73B;
        tick();
        ciphertext[0] = 16'h24EC; initialkey[0] = 16'h4AF5;
        wait_out(0, n);
        check("b2b first latency", n, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall cycle %0d", i),
                  {out_valid[0], in_ready[0], busy[0], plaintext[0]}, {3'b101, 16'h6F6B});
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("b2b after handshake", {out_valid[0], in_ready[0]}, 2'b01);
        tick();
        in_valid[0] = 1'b0;
        check("b2b second accepted", {busy[0], in_ready[0]}, 2'b10);
        wait_out(0, n);
        check("b2b second latency", n, 5);
        check("b2b second plaintext", plaintext[0], 16'hD728);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("b2b second handshake", {out_valid[0], in_ready[0]}, 2'b01);

        // Abort in RND1.
        in_valid[0] = 1'b1; ciphertext[0] = 16'h0738; initialkey[0] = 16'hA73B;
        tick();
        in_valid[0] = 1'b0;
        tick(); tick(); tick();
        check("pre-abort busy", busy[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort immediate", {out_valid[0], busy[0], in_ready[0]}, 3'b001);
        @(posedge clk);
        #2 rst_n = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0] || out_valid[1]) leaked = 1'b1;
        end
        check("no partial result", leaked, 1'b0);
        run_op(0, 16'h0738, 16'hA73B, 16'h6F6B, 5, 1'b0, "after abort");
        run_op(1, 16'h24EC, 16'h4AF5, 16'hD728, 5, 1'b0, "cache cleared");
        run_op(1, 16'h24EC, 16'h4AF5, 16'hD728, 3, 1'b1, "cache refilled");

        last_key = 16'h4AF5;
        for (int i = 0; i < 1000; i++) begin
            k = (i % 3 == 0) ? last_key : 16'($urandom);
            p = 16'($urandom);
            run_op(1, enc(p, k), k, p, (k == last_key) ? 3 : 5, 1'(i % 2),
                   $sformatf("rt%0d", i));
            last_key = k;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
